// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//
// Groups the fetch stage's instruction-memory port, the decoder-facing
// opcode port and the downstream control inputs (stall, redirect) into one
// bundle.
//
//   Parameters
//     ADDR_W      instruction address width
//     INSTR_W     instruction width
//
//   Signals
//     imem_req    fetch request this cycle                  (fetch -> imem)
//     imem_addr   fetch address (the PC register)           (fetch -> imem)
//     imem_rdata  instruction data, one cycle after request (imem  -> fetch)
//     stall       decoder not accepting this cycle          (decode -> fetch)
//     redirect    taken BEQ/JMP, flush and refetch          (decode -> fetch)
//     redirect_pc new fetch address while redirect=1        (decode -> fetch)
//     id_valid    queue head valid                          (fetch -> decode)
//     id_instr    queue head instruction, 0 when empty      (fetch -> decode)
//     id_opcode   opcode field of id_instr, 0 when empty    (fetch -> decode)
//     id_pc       address of the head instruction           (fetch -> decode)
//
//   Modports
//     master      the fetch unit
//     slave       memory plus decode environment
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               stall;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               id_valid;
   logic [INSTR_W-1:0] id_instr;
   logic [3:0]         id_opcode;
   logic [ADDR_W-1:0]  id_pc;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc,
      input  imem_rdata, stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc,
      output imem_rdata, stall, redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Issues sequential fetches to a synchronous
// instruction memory (data returns one cycle after the request), buffers the
// returned words with their addresses in a 2-entry queue, and presents the
// queue head to the decode stage. Downstream may stall (hold the head) or
// redirect (flush everything and restart fetching at redirect_pc).
//
//   Parameters
//     ADDR_W    instruction address width; the PC wraps modulo 2^ADDR_W
//     INSTR_W   instruction width; opcode is the top 4 bits
//     RESET_PC  PC value after reset
//
//   Ports
//     clk       clock, rising edge
//     rst       synchronous, active-high reset
//     bus       fetch_unit_if.master (memory port, decoder port, stall,
//               redirect)
//
//   Optional feature (compile-time macro FETCH_JMP_PREDECODE_EN)
//     When defined, a returning JMP word (opcode 4'b1111) is consumed here
//     instead of being queued: the PC is loaded from the word's low ADDR_W
//     bits and the target is fetched on the next cycle. An external redirect
//     in the same cycle takes precedence. When undefined, JMP words are
//     queued like any other instruction.
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   localparam int OPC_LSB = INSTR_W - 4;

   // Architectural state
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  req_pc;        // address of the request in flight
   logic               inflight;      // request issued last cycle, not killed
   logic [1:0]         count;         // queue occupancy, 0..2
   logic [INSTR_W-1:0] fifo_instr [2];
   logic [ADDR_W-1:0]  fifo_pc    [2];

   // Per-cycle control
   logic               head_valid;
   logic               pop;
   logic               push;
   logic               issue;
   logic               jmp_hit;
   logic [2:0]         occupancy;
   logic [1:0]         count_after_pop;

   // NOTE: every signal assigned in always_comb gets a default at the top of
   // the block, so no path can leave it unassigned and infer a latch.
   always_comb begin
      head_valid      = 1'b0;
      pop             = 1'b0;
      push            = 1'b0;
      issue           = 1'b0;
      jmp_hit         = 1'b0;
      occupancy       = 3'd0;
      count_after_pop = 2'd0;

      head_valid = (count != 2'd0);
      pop        = head_valid & ~bus.stall;

`ifdef FETCH_JMP_PREDECODE_EN
      // A returning JMP is resolved here; a same-cycle redirect still wins.
      jmp_hit = inflight & ~bus.redirect &
                (bus.imem_rdata[INSTR_W-1:OPC_LSB] == 4'b1111);
`else
      jmp_hit = 1'b0;
`endif

      // Entries that will need a queue slot: those held plus the one in
      // flight. Issuing only while that stays below 2 after this cycle's pop
      // means a response can never land on a full queue.
      occupancy = {1'b0, count} + {2'b00, inflight};
      issue     = ~rst & ~bus.redirect & ~jmp_hit &
                  (occupancy < (3'd2 + {2'b00, pop}));

      push            = inflight & ~bus.redirect & ~jmp_hit;
      count_after_pop = count - {1'b0, pop};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         req_pc   <= RESET_PC;
         inflight <= 1'b0;
         count    <= 2'd0;
      end else if (bus.redirect) begin
         // Flush: the response arriving this cycle and the queue are dropped,
         // and stall is irrelevant.
         pc       <= bus.redirect_pc;
         inflight <= 1'b0;
         count    <= 2'd0;
      end else begin
         inflight <= issue;
         count    <= count_after_pop + {1'b0, push};
         if (issue) begin
            pc     <= pc + ADDR_W'(1);
            req_pc <= pc;
         end
`ifdef FETCH_JMP_PREDECODE_EN
         // issue is forced low on a JMP hit, so this does not collide with
         // the increment above.
         if (jmp_hit) begin
            pc <= bus.imem_rdata[ADDR_W-1:0];
         end
`endif
      end
   end

   // Queue storage. Slot 0 is always the head; a pop shifts slot 1 down and
   // a push lands in the first free slot after that pop. When both hit
   // slot 0 in one cycle the push is written last and wins, which is the
   // intended result (count was 1, head leaves, new word becomes head).
   // NOTE: the queue storage has no reset; count alone says which slots are
   // meaningful and the outputs are masked when the queue is empty.
   always_ff @(posedge clk) begin
      if (pop) begin
         fifo_instr[0] <= fifo_instr[1];
         fifo_pc[0]    <= fifo_pc[1];
      end
      if (push) begin
         if (count_after_pop == 2'd0) begin
            fifo_instr[0] <= bus.imem_rdata;
            fifo_pc[0]    <= req_pc;
         end else begin
            fifo_instr[1] <= bus.imem_rdata;
            fifo_pc[1]    <= req_pc;
         end
      end
   end

   // Outputs
   assign bus.imem_req  = issue;
   assign bus.imem_addr = pc;
   assign bus.id_valid  = head_valid;
   assign bus.id_instr  = head_valid ? fifo_instr[0] : '0;
   assign bus.id_opcode = head_valid ? fifo_instr[0][INSTR_W-1:OPC_LSB] : 4'b0000;
   assign bus.id_pc     = head_valid ? fifo_pc[0] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The driver walks a cycle-indexed script
// (reset, stall, redirect with stall, redirect in flight, JMP word) and
// pushes the expected delivery order {pc, instr} into a queue. A monitor
// compares every delivered head (id_valid & ~stall, outside redirect and
// reset) against the front of that queue. A second instance with
// RESET_PC=0xFE checks PC wrap-around. The memory model returns
// 0x1000+addr, and 0xF020 at address 2 during the JMP phase.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] instr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stall = 1'b0;
   logic       redirect = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic       jmp_word_en = 1'b0;

   int   n_checks = 0;
   int   n_fail   = 0;

   exp_t exp_q[$];
   exp_t wrap_q[$];

   always #5 clk = ~clk;

   // Main DUT
   fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) m_if ();
   fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (m_if)
   );

   // Wrap-around DUT
   fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) w_if ();
   fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) u_dut_wrap (
      .clk (clk),
      .rst (rst),
      .bus (w_if)
   );

   assign m_if.stall       = stall;
   assign m_if.redirect    = redirect;
   assign m_if.redirect_pc = redirect_pc;
   assign w_if.stall       = 1'b0;
   assign w_if.redirect    = 1'b0;
   assign w_if.redirect_pc = 8'h00;

   function automatic logic [15:0] mem_word(input logic [7:0] a);
      if (jmp_word_en && a == 8'h02) return 16'hF020;
      return 16'h1000 + {8'h00, a};
   endfunction

   // Synchronous instruction memories
   always @(posedge clk) begin
      m_if.imem_rdata <= m_if.imem_req ? mem_word(m_if.imem_addr) : 16'hDEAD;
      w_if.imem_rdata <= w_if.imem_req ? mem_word(w_if.imem_addr) : 16'hDEAD;
   end

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] p);
      exp_t e;
      e.pc    = p;
      e.instr = mem_word(p);
      return e;
   endfunction

   // Scoreboard monitor: main DUT
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (m_if.id_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_delivery: got pc %h instr %h, expected none",
                        m_if.id_pc, m_if.id_instr);
            end else begin
               e = exp_q.pop_front();
               check("deliver_pc",     32'(m_if.id_pc),     32'(e.pc));
               check("deliver_instr",  32'(m_if.id_instr),  32'(e.instr));
               check("deliver_opcode", 32'(m_if.id_opcode), 32'(e.instr[15:12]));
            end
         end else if (!m_if.id_valid) begin
            check("empty_outputs_zero",
                  32'({m_if.id_instr, m_if.id_opcode, m_if.id_pc}), 32'd0);
         end
      end
   end

   // Scoreboard monitor: wrap DUT (only while expectations remain)
   always @(negedge clk) begin
      exp_t e;
      if (!rst && w_if.id_valid && wrap_q.size() != 0) begin
         e = wrap_q.pop_front();
         check("wrap_pc",    32'(w_if.id_pc),    32'(e.pc));
         check("wrap_instr", 32'(w_if.id_instr), 32'(e.instr));
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) next_cycle();

      // Reset state
      @(negedge clk);
      check("rst_imem_req",  32'(m_if.imem_req),  32'd0);
      check("rst_imem_addr", 32'(m_if.imem_addr), 32'h00);
      check("rst_id_valid",  32'(m_if.id_valid),  32'd0);
      check("rst_id_fields", 32'({m_if.id_instr, m_if.id_opcode, m_if.id_pc}), 32'd0);
      check("rst_count",     32'(u_dut.count),    32'd0);
      check("rst_inflight",  32'(u_dut.inflight), 32'd0);
      check("rst_wrap_addr", 32'(w_if.imem_addr), 32'hFE);
      next_cycle();

      // Expected delivery order for the main script
      for (int p = 0; p <= 6; p++) exp_q.push_back(mk(8'(p)));
      for (int p = 8'h40; p <= 8'h42; p++) exp_q.push_back(mk(8'(p)));
      for (int p = 8'h80; p <= 8'h84; p++) exp_q.push_back(mk(8'(p)));
      wrap_q.push_back(mk(8'hFE));
      wrap_q.push_back(mk(8'hFF));
      wrap_q.push_back(mk(8'h00));

      rst = 1'b0;
      for (int c = 0; c <= 29; c++) begin
         stall       = (c >= 5 && c <= 9) || (c >= 14 && c <= 16);
         redirect    = (c == 16) || (c == 22);
         redirect_pc = (c == 16) ? 8'h40 : 8'h80;
         @(negedge clk);
         case (c)
            0: begin
               check("first_req",      32'(m_if.imem_req),  32'd1);
               check("first_req_addr", 32'(m_if.imem_addr), 32'h00);
            end
            1: begin
               check("c1_id_valid",  32'(m_if.id_valid),  32'd0);
               check("c1_imem_addr", 32'(m_if.imem_addr), 32'h01);
            end
            2: check("c2_id_valid", 32'(m_if.id_valid), 32'd1);
            7: begin
               check("stall_count_sat", 32'(u_dut.count),   32'd2);
               check("stall_no_req",    32'(m_if.imem_req), 32'd0);
               check("stall_head_pc",   32'(m_if.id_pc),    32'h03);
            end
            9: check("stall_no_req_end", 32'(m_if.imem_req), 32'd0);
            10: begin
               check("release_reissue",      32'(m_if.imem_req),  32'd1);
               check("release_reissue_addr", 32'(m_if.imem_addr), 32'h05);
            end
            17: begin
               check("redir1_r1_valid", 32'(m_if.id_valid),  32'd0);
               check("redir1_r1_req",   32'(m_if.imem_req),  32'd1);
               check("redir1_r1_addr",  32'(m_if.imem_addr), 32'h40);
            end
            18: check("redir1_r2_valid", 32'(m_if.id_valid), 32'd0);
            23: begin
               check("redir2_r1_valid", 32'(m_if.id_valid),  32'd0);
               check("redir2_r1_req",   32'(m_if.imem_req),  32'd1);
               check("redir2_r1_addr",  32'(m_if.imem_addr), 32'h80);
            end
            24: check("redir2_r2_valid", 32'(m_if.id_valid), 32'd0);
            default: ;
         endcase
         next_cycle();
      end

      // Reset mid-operation, then the JMP phase
      stall       = 1'b0;
      redirect    = 1'b0;
      rst         = 1'b1;
      jmp_word_en = 1'b1;
      next_cycle();
      @(negedge clk);
      check("midrst_id_valid", 32'(m_if.id_valid), 32'd0);
      check("midrst_addr",     32'(m_if.imem_addr), 32'h00);
      next_cycle();

`ifdef FETCH_JMP_PREDECODE_EN
      exp_q.push_back(mk(8'h00));
      exp_q.push_back(mk(8'h01));
      exp_q.push_back(mk(8'h20));
      exp_q.push_back(mk(8'h21));
      exp_q.push_back(mk(8'h22));
`else
      for (int p = 0; p <= 6; p++) exp_q.push_back(mk(8'(p)));
`endif

      rst = 1'b0;
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
`ifdef FETCH_JMP_PREDECODE_EN
         if (c == 3) check("jmp_req_suppressed", 32'(m_if.imem_req), 32'd0);
         if (c == 4) begin
            check("jmp_target_req",  32'(m_if.imem_req),  32'd1);
            check("jmp_target_addr", 32'(m_if.imem_addr), 32'h20);
         end
         if (c == 5) check("jmp_gap_valid", 32'(m_if.id_valid), 32'd0);
`else
         if (c == 4) begin
            check("jmp_queued_pc",     32'(m_if.id_pc),     32'h02);
            check("jmp_queued_opcode", 32'(m_if.id_opcode), 32'hF);
         end
`endif
         next_cycle();
      end

      rst = 1'b1;
      next_cycle();
      check("scoreboard_drained",      32'(exp_q.size()),  32'd0);
      check("wrap_scoreboard_drained", 32'(wrap_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
